// File: rtl/writeback_arbiter_if.sv
// Bundle of result-source handshakes, issue/query scoreboard ports and the
// register-file write port seen by the writeback arbiter.
interface writeback_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
);
    logic                  alu_valid;
    logic [ADDR_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  alu_ready;

    logic                  mem_valid;
    logic [ADDR_WIDTH-1:0] mem_rd;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_ready;

    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic                  issue_ready;

    logic [ADDR_WIDTH-1:0] query_rd1;
    logic [ADDR_WIDTH-1:0] query_rd2;
    logic                  pending1;
    logic                  pending2;

    logic                  reg_write;
    logic [ADDR_WIDTH-1:0] write_register;
    logic [DATA_WIDTH-1:0] write_data;

    // Pipeline side: offers results, issues instructions, queries hazards.
    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        output issue_valid, issue_rd,
        input  issue_ready,
        output query_rd1, query_rd2,
        input  pending1, pending2,
        input  reg_write, write_register, write_data
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        input  issue_valid, issue_rd,
        output issue_ready,
        input  query_rd1, query_rd2,
        output pending1, pending2,
        output reg_write, write_register, write_data
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Two-source writeback arbiter (load-priority with ALU anti-starvation) feeding
// one register-file write port, plus a per-register in-flight write scoreboard.
module writeback_arbiter #(
    parameter int NUM_REGS   = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    writeback_arbiter_if.slave    bus
);

    logic [1:0]                     starve_cnt_reg;
    logic [1:0]                     starve_cnt_next;
    logic                           alu_wins;
    logic                           mem_wins;
    logic                           alu_xfer;
    logic                           mem_xfer;
    logic                           xfer;
    logic [ADDR_WIDTH-1:0]          xfer_rd;
    logic [DATA_WIDTH-1:0]          xfer_data;
    logic                           issue_rec;

    logic                           reg_write_reg;
    logic [ADDR_WIDTH-1:0]          write_register_reg;
    logic [DATA_WIDTH-1:0]          write_data_reg;

    logic [NUM_REGS-1:0][1:0]       cnt_reg;
    logic [NUM_REGS-1:0][1:0]       cnt_next;

    // Loads win unless the ALU has already lost twice in a row.
    always_comb begin
        alu_wins = bus.alu_valid && (!bus.mem_valid || (starve_cnt_reg == 2'd2));
        mem_wins = bus.mem_valid && !alu_wins;
    end

    assign bus.alu_ready = alu_wins && !rst;
    assign bus.mem_ready = mem_wins && !rst;

    assign alu_xfer  = bus.alu_valid && bus.alu_ready;
    assign mem_xfer  = bus.mem_valid && bus.mem_ready;
    assign xfer      = alu_xfer || mem_xfer;
    assign xfer_rd   = alu_xfer ? bus.alu_rd   : bus.mem_rd;
    assign xfer_data = alu_xfer ? bus.alu_data : bus.mem_data;

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!bus.alu_valid || alu_xfer) begin
            starve_cnt_next = 2'd0;
        end else if (starve_cnt_reg != 2'd2) begin
            starve_cnt_next = starve_cnt_reg + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_reg     <= 2'd0;
            reg_write_reg      <= 1'b0;
            write_register_reg <= '0;
            write_data_reg     <= '0;
            cnt_reg            <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            cnt_reg        <= cnt_next;
            reg_write_reg  <= xfer && (xfer_rd != '0);
            if (xfer) begin
                write_register_reg <= xfer_rd;
                write_data_reg     <= xfer_data;
            end
        end
    end

    assign bus.reg_write      = reg_write_reg;
    assign bus.write_register = write_register_reg;
    assign bus.write_data     = write_data_reg;

    // A counter at 3 cannot take another issue, so increments never wrap.
    assign bus.issue_ready = !rst && (cnt_reg[bus.issue_rd] != 2'd3);
    assign issue_rec       = bus.issue_valid && bus.issue_ready && (bus.issue_rd != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
            logic inc;
            logic dec;
            assign inc = issue_rec && (bus.issue_rd == ADDR_WIDTH'(gi));
            assign dec = xfer && (xfer_rd != '0) && (xfer_rd == ADDR_WIDTH'(gi));
            // Simultaneous issue and retire cancel; a retire at zero is ignored.
            assign cnt_next[gi] = (inc && !dec) ? cnt_reg[gi] + 2'd1 :
                                  (dec && !inc && (cnt_reg[gi] != 2'd0)) ? cnt_reg[gi] - 2'd1 :
                                  cnt_reg[gi];
        end
    endgenerate

    assign bus.pending1 = (bus.query_rd1 != '0) && (cnt_reg[bus.query_rd1] != 2'd0);
    assign bus.pending2 = (bus.query_rd2 != '0) && (cnt_reg[bus.query_rd2] != 2'd0);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: arbitration order, writeback timing,
// scoreboard saturation/cancellation and reset behaviour.
module tb_writeback_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    writeback_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) bus ();

    writeback_arbiter #(
        .NUM_REGS   (32),
        .DATA_WIDTH (64),
        .ADDR_WIDTH (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] alu_win_seq;
        checks   = 0;
        failures = 0;

        bus.alu_valid   = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid   = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
        bus.issue_valid = 1'b0; bus.issue_rd = '0;
        bus.query_rd1   = '0;   bus.query_rd2 = '0;
        rst = 1'b1;

        // Readies held low during reset even with offers present
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 64'h99;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd6;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
        #1;
        check("rst_alu_ready", bus.alu_ready, 1'b0);
        check("rst_mem_ready", bus.mem_ready, 1'b0);
        check("rst_issue_ready", bus.issue_ready, 1'b0);
        tick();
        check("rst_reg_write", bus.reg_write, 1'b0);
        check("rst_write_register", bus.write_register, 5'd0);
        check("rst_write_data", bus.write_data, 64'h0);
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0; bus.issue_valid = 1'b0;
        bus.query_rd1 = 5'd3;
        tick();
        rst = 1'b0;
        #1;
        check("rst_pending_r3", bus.pending1, 1'b0);
        check("idle_alu_ready", bus.alu_ready, 1'b0);
        check("idle_mem_ready", bus.mem_ready, 1'b0);

        // Single ALU transfer
        tick();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 64'h1234;
        #1;
        check("alu_single_ready", bus.alu_ready, 1'b1);
        check("alu_single_mem_ready", bus.mem_ready, 1'b0);
        tick();
        bus.alu_valid = 1'b0;
        check("alu_single_reg_write", bus.reg_write, 1'b1);
        check("alu_single_write_register", bus.write_register, 5'd5);
        check("alu_single_write_data", bus.write_data, 64'h1234);
        tick();
        check("idle_reg_write", bus.reg_write, 1'b0);
        check("idle_hold_write_register", bus.write_register, 5'd5);
        check("idle_hold_write_data", bus.write_data, 64'h1234);

        // Contention: mem, mem, alu, mem
        alu_win_seq = 4'b0100;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd3; bus.mem_data = 64'hAAAA;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 64'hBBBB;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("contend%0d_alu_ready", i), bus.alu_ready, alu_win_seq[i]);
            check($sformatf("contend%0d_mem_ready", i), bus.mem_ready, !alu_win_seq[i]);
            tick();
            check($sformatf("contend%0d_write_register", i), bus.write_register,
                  alu_win_seq[i] ? 64'd4 : 64'd3);
            check($sformatf("contend%0d_write_data", i), bus.write_data,
                  alu_win_seq[i] ? 64'hBBBB : 64'hAAAA);
        end
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
        tick();

        // Write to register 0: accepted but no register-file write
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 64'h55;
        bus.query_rd1 = 5'd0;
        #1;
        check("r0_mem_ready", bus.mem_ready, 1'b1);
        tick();
        bus.mem_valid = 1'b0;
        check("r0_reg_write", bus.reg_write, 1'b0);
        check("r0_pending", bus.pending1, 1'b0);

        // Scoreboard saturation on r7
        bus.query_rd1 = 5'd7;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        #1;
        check("sat_pending_before", bus.pending1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("sat_issue%0d_ready", i), bus.issue_ready, 1'b1);
            tick();
        end
        #1;
        check("sat_pending_r7", bus.pending1, 1'b1);
        check("sat_issue_ready_r7", bus.issue_ready, 1'b0);
        tick();
        bus.issue_valid = 1'b0;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 64'h77;
        #1;
        check("sat_same_cycle_issue_ready", bus.issue_ready, 1'b0);
        tick();
        bus.mem_valid = 1'b0;
        #1;
        check("sat_after_retire_issue_ready", bus.issue_ready, 1'b1);
        check("sat_after_retire_pending", bus.pending1, 1'b1);
        bus.mem_valid = 1'b1;
        tick();
        tick();
        bus.mem_valid = 1'b0;
        #1;
        check("sat_drained_pending", bus.pending1, 1'b0);

        // Simultaneous issue and retire on r9
        bus.query_rd2 = 5'd9;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        tick();
        #1;
        check("sim_pending_cnt1", bus.pending2, 1'b1);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 64'h9999;
        #1;
        check("sim_alu_ready", bus.alu_ready, 1'b1);
        tick();
        bus.issue_valid = 1'b0;
        #1;
        check("sim_pending_still", bus.pending2, 1'b1);
        tick();
        bus.alu_valid = 1'b0;
        #1;
        check("sim_pending_cleared", bus.pending2, 1'b0);

        // Reset mid-transfer on r2
        bus.query_rd1 = 5'd2;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd2;
        tick();
        bus.issue_valid = 1'b0;
        #1;
        check("rstmid_pending_before", bus.pending1, 1'b1);
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd2; bus.mem_data = 64'h2222;
        rst = 1'b1;
        #1;
        check("rstmid_mem_ready", bus.mem_ready, 1'b0);
        tick();
        rst = 1'b0;
        bus.mem_valid = 1'b0;
        check("rstmid_reg_write", bus.reg_write, 1'b0);
        check("rstmid_pending_r2", bus.pending1, 1'b0);

        // First cycle after reset accepts a transfer
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 64'h6666;
        #1;
        check("post_rst_alu_ready", bus.alu_ready, 1'b1);
        tick();
        bus.alu_valid = 1'b0;
        check("post_rst_reg_write", bus.reg_write, 1'b1);
        check("post_rst_write_register", bus.write_register, 5'd6);
        check("post_rst_write_data", bus.write_data, 64'h6666);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter NUM_REGS, default 32, SHALL set the number of architectural registers tracked.
REQ-002 Parameter DATA_WIDTH, default 64, SHALL set the width of the result data.
REQ-003 Parameter ADDR_WIDTH, default 5, SHALL set the width of register numbers, equal to clog2(NUM_REGS).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 The ports SHALL be as follows:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result offered.
- alu_rd  in  ADDR_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- alu_ready  out  1  ALU result accepted this cycle.
- mem_valid  in  1  load result offered.
- mem_rd  in  ADDR_WIDTH  load destination register.
- mem_data  in  DATA_WIDTH  load result.
- mem_ready  out  1  load result accepted this cycle.
- issue_valid  in  1  an instruction with destination issue_rd is issuing.
- issue_rd  in  ADDR_WIDTH  destination of the issuing instruction.
- issue_ready  out  1  the issue can be recorded.
- query_rd1, query_rd2  in  ADDR_WIDTH  operand registers to check.
- pending1, pending2  out  1  the queried register has an outstanding write.
- reg_write  out  1  register-file write enable.
- write_register  out  ADDR_WIDTH  register-file write address.
- write_data  out  DATA_WIDTH  register-file write data.

Function
REQ-006 A source transfer SHALL occur on a cycle in which its valid and ready are both 1; at most one transfer SHALL occur per cycle.
REQ-007 Arbitration SHALL be combinational: the load source wins by default; the ALU source wins when starve_cnt == 2.
REQ-008 When only one source is valid, that source SHALL win.
REQ-009 The ready of the winning source SHALL be 1 and the ready of the losing source SHALL be 0; with no valid source, both readies SHALL be 0.
REQ-010 The 2-bit counter starve_cnt SHALL behave as follows:
- increment when alu_valid=1 and the ALU loses;
- clear to 0 on an ALU transfer or when alu_valid=0;
- never exceed 2.
REQ-011 A transfer SHALL appear at the register-file port exactly one cycle later:
- reg_write = 1 if rd != 0, otherwise 0;
- write_register = rd;
- write_data = data.
REQ-012 In a cycle with no transfer, reg_write SHALL be 0 the following cycle; write_register and write_data SHALL hold their previous values.
REQ-013 Each register r SHALL have a 2-bit in-flight counter cnt[r].
REQ-014 issue_ready SHALL be 0 when cnt[issue_rd] == 3, and 1 otherwise.
REQ-015 An issue SHALL be recorded when issue_valid=1, issue_ready=1 and issue_rd != 0; issues to register 0 SHALL never be recorded.
REQ-016 A recorded issue SHALL increment cnt[issue_rd] at the clock edge.
REQ-017 A transfer with rd != 0 SHALL decrement cnt[rd] at the same edge as the transfer handshake.
REQ-018 If cnt[rd] == 0 at a decrement, the counter SHALL stay at 0.
REQ-019 A same-cycle issue and transfer to the same register SHALL leave that counter unchanged.
REQ-020 The pending outputs SHALL be combinational from current state: pendingN = (cnt[query_rdN] != 0).
REQ-021 pendingN SHALL be 0 for query_rdN == 0.
REQ-022 The pending outputs SHALL NOT reflect same-cycle issues or transfers.
REQ-023 alu_ready, mem_ready and issue_ready SHALL each be 0 while rst=1.

Reset
REQ-024 At the first rising edge with rst=1, the following SHALL be set:
- reg_write = 0;
- write_register = 0;
- write_data = 0;
- starve_cnt = 0;
- every cnt[r] = 0.
REQ-025 Reset asserted mid-transfer SHALL discard the pending register-file write: reg_write SHALL be 0 on the cycle after the reset edge.
REQ-026 After rst deasserts, the block SHALL accept transfers and issues on the first cycle.

Verification
REQ-027 The bench SHALL cover a single ALU transfer: alu_valid=1, alu_rd=5, alu_data=0x1234 -> alu_ready=1 that cycle; the next cycle reg_write=1, write_register=5, write_data=0x1234.
REQ-028 The bench SHALL cover contention and anti-starvation: both sources valid for 4 cycles (mem_rd=3, alu_rd=4) -> winners in order mem, mem, alu, mem.
REQ-029 The bench SHALL cover a write to register 0: mem_valid=1, mem_rd=0 -> mem_ready=1; the next cycle reg_write=0 and no counter changes.
REQ-030 The bench SHALL cover scoreboard saturation: three issues to rd=7 -> pending for query 7 = 1 and issue_ready for rd 7 = 0; one transfer to rd 7 -> issue_ready = 1 on the next cycle.
REQ-031 The bench SHALL cover simultaneous issue and retire: cnt[9]=1, same-cycle issue to rd 9 and ALU transfer to rd 9 -> cnt[9] stays 1 and pending for query 9 stays 1.
REQ-032 The bench SHALL cover reset mid-operation: a transfer to rd 2 and rst=1 asserted in the same cycle -> on the next cycle reg_write=0 and pending for query 2 = 0.
